disp_word_packer: RTL and testbench

- Downstream of the per-block minimum-distance stage.
- Takes one best-match result per block (`res_coords`, `res_blk_index`, `res_valid`).
- Masks low-confidence and invalid matches, then packs four 8-bit disparities into 32-bit words.
- Buffers words in a small FIFO and drives a valid/ready stream with SOP/EOP framing toward the frame-buffer writer.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/disp_sync_fifo.sv | 64 ++++++
 rtl/disp_word_packer.sv | 147 ++++++++++++++
 tb/tb_disp_word_packer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the disparity word packer.
package disp_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int LANE_CW   = $clog2(NUM_LANES);

  localparam logic [15:0]       DISP_INVALID_COORDS = 16'hFFFF;
  localparam logic [LANE_W-1:0] DISP_MASKED_BYTE    = 8'h00;

  // One FIFO entry: framing flags travel with the packed word
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } disp_word_t;

  // A match is dropped when upstream flagged it invalid or it is below threshold
  function automatic logic disp_is_masked(input logic [15:0] coords,
                                          input logic [7:0]  thresh);
    return (coords == DISP_INVALID_COORDS) || (coords[15:8] < thresh);
  endfunction

endpackage

// File: rtl/disp_sync_fifo.sv
// Synchronous FWFT FIFO with a registered output stage.
// The output register counts toward DEPTH, so capacity is exactly DEPTH words.
// A write while full is accepted when a read happens in the same cycle.
module disp_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             rd_valid;
  logic             pop, push, load, ram_empty, bypass;

  assign empty     = !rd_valid;
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = rd_valid && rd_en;
  assign push      = wr_en && (!full || pop);
  assign ram_empty = ((count - (AW+1)'(rd_valid)) == '0);
  // Output register is free to take a new head this cycle
  assign load      = !rd_valid || pop;
  // Straight into the output register when nothing is queued behind it
  assign bypass    = load && ram_empty && push;

  // Storage array, written only when the word cannot go straight to the output
  always_ff @(posedge clk) begin
    if (push && !bypass) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the registered head word
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push && !bypass) wr_ptr <= wr_ptr + 1'b1;
      if (load && !ram_empty) begin
        rd_data  <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
        rd_valid <= 1'b1;
      end else if (bypass) begin
        rd_data  <= wr_data;
        rd_valid <= 1'b1;
      end else if (load) begin
        rd_valid <= 1'b0;  // rd_data keeps the last word
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/disp_word_packer.sv
// Masks per-block disparity matches and packs four 8-bit disparities per
// 32-bit word, framed with SOP/EOP, through a small output FIFO.
// Optional: define DISP_INVALID_COUNT_EN to add the invalid_count port.
module disp_word_packer
  import disp_pkg::*;
#(
  parameter int blks_per_row = 40,
  parameter int blk_rows     = 30,
  parameter int fifo_depth   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [15:0] res_coords,
  input  logic [15:0] res_blk_index,
  input  logic        res_valid,
  input  logic [7:0]  conf_thresh,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        overflow,
  output logic        idx_err
`ifdef DISP_INVALID_COUNT_EN
  ,
  output logic [15:0] invalid_count
`endif
);
  localparam int words_per_frame = blks_per_row * blk_rows / NUM_LANES;
  localparam int blks_per_frame  = blks_per_row * blk_rows;

  localparam logic [15:0]        LAST_WORD = 16'(words_per_frame - 1);
  localparam logic [11:0]        LAST_BLK  = 12'(blks_per_frame - 1);
  localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(NUM_LANES - 1);

  logic [LANE_CW-1:0]               lane_cnt, lane_eff;
  logic [15:0]                      word_cnt, word_eff;
  logic [11:0]                      blk_cnt, blk_eff;
  logic [NUM_LANES-1:0][LANE_W-1:0] lanes_q, lanes_asm;
  logic                             masked;
  logic [LANE_W-1:0]                res_byte;
  logic                             push, word_sop, word_eop;
  disp_word_t                       push_word, head_word;
  logic                             fifo_full, fifo_empty, fifo_pop;
  logic                             unused_bits;

  assign unused_bits = ^{res_blk_index[15:12], res_coords[2:0]};

  // frame_start acts in the cycle it is seen, so counters restart combinationally
  assign lane_eff = frame_start ? '0 : lane_cnt;
  assign word_eff = frame_start ? '0 : word_cnt;
  assign blk_eff  = frame_start ? '0 : blk_cnt;

  assign masked   = disp_is_masked(res_coords, conf_thresh);
  assign res_byte = masked ? DISP_MASKED_BYTE : {res_coords[7:3], 3'b000};

  // Per-lane merge: the incoming byte lands in its lane, others keep (or drop) history
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lanes_asm[i] = (res_valid && lane_eff == LANE_CW'(i)) ? res_byte :
                          (frame_start ? DISP_MASKED_BYTE : lanes_q[i]);
  end

  assign push      = res_valid && (lane_eff == LAST_LANE);
  assign word_sop  = (word_eff == '0);
  assign word_eop  = (word_eff == LAST_WORD);
  assign push_word = '{sop: word_sop, eop: word_eop, data: lanes_asm};

  // Lane, word and block counters plus the partial-word holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_cnt <= '0;
      word_cnt <= '0;
      blk_cnt  <= '0;
      lanes_q  <= '0;
    end else begin
      if (res_valid) begin
        lane_cnt <= push ? '0 : lane_eff + 1'b1;
        lanes_q  <= push ? '0 : lanes_asm;
        blk_cnt  <= (blk_eff == LAST_BLK) ? '0 : blk_eff + 12'd1;
      end else if (frame_start) begin
        lane_cnt <= '0;
        lanes_q  <= '0;
        blk_cnt  <= '0;
      end
      // Counter advances even if the FIFO drops the word, keeping framing aligned
      if (push)             word_cnt <= word_eop ? '0 : word_eff + 16'd1;
      else if (frame_start) word_cnt <= '0;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      idx_err  <= 1'b0;
    end else begin
      if (push && fifo_full && !fifo_pop)                     overflow <= 1'b1;
      if (res_valid && (res_blk_index[11:0] != blk_eff))      idx_err  <= 1'b1;
    end
  end

  disp_sync_fifo #(
    .WIDTH ($bits(disp_word_t)),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (out_ready),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign out_data  = head_word.data;
  assign out_sop   = out_valid && head_word.sop;
  assign out_eop   = out_valid && head_word.eop;

`ifdef DISP_INVALID_COUNT_EN
  logic [15:0] inv_cnt, inv_base, inv_sum;

  assign inv_base = frame_start ? '0 : inv_cnt;
  assign inv_sum  = (masked && inv_base != 16'hFFFF) ? inv_base + 16'd1 : inv_base;

  // Running masked-byte count; published when the frame's last word is pushed
  always_ff @(posedge clk) begin
    if (reset) begin
      inv_cnt       <= '0;
      invalid_count <= '0;
    end else if (res_valid) begin
      if (push && word_eop) begin
        invalid_count <= inv_sum;
        inv_cnt       <= '0;
      end else begin
        inv_cnt <= inv_sum;
      end
    end else if (frame_start) begin
      inv_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_disp_word_packer.sv
// Randomized self-checking bench for disp_word_packer with a queue-based
// reference model. Define DISP_INVALID_COUNT_EN to also cover invalid_count.
module tb_disp_word_packer;
  localparam int BPR   = 4;
  localparam int ROWS  = 2;
  localparam int DEPTH = 4;
  localparam int WPF   = BPR * ROWS / 4;
  localparam int NBLK  = BPR * ROWS;

  logic        clk = 1'b0, reset = 1'b1, frame_start = 1'b0, res_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] res_coords = '0, res_blk_index = '0;
  logic [7:0]  conf_thresh = '0;
  logic [31:0] out_data;
  logic        out_valid, out_sop, out_eop, overflow, idx_err;
`ifdef DISP_INVALID_COUNT_EN
  logic [15:0] invalid_count;
`endif

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  disp_word_packer #(.blks_per_row(BPR), .blk_rows(ROWS), .fifo_depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .res_coords(res_coords),
    .res_blk_index(res_blk_index), .res_valid(res_valid), .conf_thresh(conf_thresh),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .overflow(overflow), .idx_err(idx_err)
`ifdef DISP_INVALID_COUNT_EN
    , .invalid_count(invalid_count)
`endif
  );

  // Reference model: {sop, eop, data} words
  logic [33:0] m_q[$], exp_q[$], obs_q[$];
  logic [7:0]  m_bytes[$];
  logic [33:0] m_w;
  int          m_word, m_blk;
  bit          m_ovf, m_idx, m_pop, m_msk;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete(); m_bytes.delete();
      m_word = 0; m_blk = 0; m_ovf = 0; m_idx = 0;
    end else begin
      m_pop = (m_q.size() > 0) && out_ready;
      if (m_pop) exp_q.push_back(m_q.pop_front());
      if (frame_start) begin m_bytes.delete(); m_word = 0; m_blk = 0; end
      if (res_valid) begin
        if (int'(res_blk_index[11:0]) != m_blk) m_idx = 1;
        m_blk = (m_blk + 1) % NBLK;
        m_msk = (res_coords == 16'hFFFF) || (res_coords[15:8] < conf_thresh);
        m_bytes.push_back(m_msk ? 8'h00 : (8'(res_coords[7:3]) << 3));
        if (m_bytes.size() == 4) begin
          m_w = {(m_word == 0), (m_word == WPF - 1), m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          if (m_q.size() >= DEPTH) m_ovf = 1;
          else m_q.push_back(m_w);
          m_word = (m_word + 1) % WPF;
          m_bytes.delete();
        end
      end
    end
  end

  // Record every word the consumer takes
  always @(negedge clk)
    if (!reset && out_valid && out_ready) obs_q.push_back({out_sop, out_eop, out_data});

  function automatic logic [15:0] rnd_coords();
    logic [15:0] c;
    if ($urandom_range(0, 7) == 0) return 16'hFFFF;
    c = 16'($urandom);
    c[2:0] = 3'b000;
    return c;
  endfunction

  task automatic send(input logic [15:0] c, input int idx, input bit fs);
    @(posedge clk); #1;
    res_valid = 1'b1; res_coords = c; res_blk_index = 16'(idx); frame_start = fs;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; res_valid = 1'b0; frame_start = 1'b0; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset = 1'b1; res_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1; reset = 1'b0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic drain();
    int k;
    @(posedge clk); #1; out_ready = 1'b1; res_valid = 1'b0; frame_start = 1'b0;
    for (k = 0; k < 200 && m_q.size() != 0; k++) begin @(posedge clk); #1; end
    n_vec++;
    if (m_q.size() != 0) begin n_err++; $display("FAIL drain_timeout: %0d words still queued", m_q.size()); end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec += 6;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_sop   !== 1'b0) begin n_err++; $display("FAIL reset_sop: got %b want 0", out_sop); end
    if (out_eop   !== 1'b0) begin n_err++; $display("FAIL reset_eop: got %b want 0", out_eop); end
    if (overflow  !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    if (idx_err   !== 1'b0) begin n_err++; $display("FAIL reset_idx: got %b want 0", idx_err); end
    if (out_data  !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    @(posedge clk); #1; reset = 1'b0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_pack_mask();
    conf_thresh = 8'h10; out_ready = 1'b1;
    send(16'h2028, 0, 0); send(16'h0530, 1, 0); send(16'hFFFF, 2, 0);
    send(16'h4010, 3, 0);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL pack_early: valid %b want 0", out_valid); end
    idle(1);
    @(negedge clk);
    n_vec += 4;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL pack_latency: valid %b want 1", out_valid); end
    if (out_data !== 32'h10000028) begin n_err++; $display("FAIL pack_data: got %h want 10000028", out_data); end
    if (out_sop !== 1'b1) begin n_err++; $display("FAIL pack_sop: got %b want 1", out_sop); end
    if (out_eop !== 1'b0) begin n_err++; $display("FAIL pack_eop: got %b want 0", out_eop); end
    for (int i = 0; i < 4; i++) send(rnd_coords(), m_blk, 0);
    drain();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL pack_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL pack_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_framing();
    conf_thresh = 8'($urandom_range(0, 255));
    for (int i = 0; i < 12; i++) send(rnd_coords(), m_blk, 0);
    drain();
    n_vec++;
    if (obs_q.size() != 3) begin n_err++; $display("FAIL frame_count: got %0d want 3", obs_q.size()); end
    else begin
      n_vec += 2;
      if (obs_q[1][32] !== 1'b1) begin n_err++; $display("FAIL frame_eop: got %b want 1", obs_q[1][32]); end
      if (obs_q[2][33] !== 1'b1) begin n_err++; $display("FAIL frame_sop: got %b want 1", obs_q[2][33]); end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL frame_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    conf_thresh = 8'($urandom_range(0, 255));
    for (int i = 0; i < 20; i++) begin
      send(rnd_coords(), m_blk, 0);
      if (i == 16) begin
        @(negedge clk);
        n_vec++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    idle(1);
    @(negedge clk);
    n_vec += 2;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
    if (overflow !== m_ovf) begin n_err++; $display("FAIL ovf_model: got %b want %b", overflow, m_ovf); end
    drain();
    n_vec++;
    if (obs_q.size() != 4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec += 2;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid: got %b want 0", out_valid); end
    if (exp_q.size() > 0 && out_data !== exp_q[exp_q.size()-1][31:0]) begin
      n_err++; $display("FAIL empty_hold: got %h want %h", out_data, exp_q[exp_q.size()-1][31:0]);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_midword_fs();
    do_reset();
    conf_thresh = 8'($urandom_range(0, 128));
    send(rnd_coords(), 0, 0); send(rnd_coords(), 1, 0);
    @(posedge clk); #1; res_valid = 1'b0; frame_start = 1'b1;
    for (int i = 0; i < 4; i++) send(rnd_coords(), i, 0);
    drain();
    n_vec += 2;
    if (obs_q.size() != 1) begin n_err++; $display("FAIL fs_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0 && obs_q[0][33] !== 1'b1) begin n_err++; $display("FAIL fs_sop: got %b want 1", obs_q[0][33]); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fs_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_index();
    do_reset();
    send(rnd_coords(), 0, 0); send(rnd_coords(), 1, 0); send(rnd_coords(), 3, 0);
    @(negedge clk);
    n_vec++;
    if (idx_err !== 1'b0) begin n_err++; $display("FAIL idx_early: got %b want 0", idx_err); end
    idle(1);
    @(negedge clk);
    n_vec++;
    if (idx_err !== 1'b1) begin n_err++; $display("FAIL idx_set: got %b want 1", idx_err); end
    idle(5);
    @(negedge clk);
    n_vec++;
    if (idx_err !== 1'b1) begin n_err++; $display("FAIL idx_sticky: got %b want 1", idx_err); end
    do_reset();
    @(negedge clk);
    n_vec++;
    if (idx_err !== 1'b0) begin n_err++; $display("FAIL idx_clear: got %b want 0", idx_err); end
  endtask

  task automatic test_random();
    bit fs;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (c % 8 == 0)   out_ready = ($urandom_range(0, 3) != 0);
      if (c % 100 == 0) conf_thresh = 8'($urandom);
      fs = ($urandom_range(0, 60) == 0);
      frame_start   = fs;
      res_valid     = ($urandom_range(0, 4) != 0);
      res_coords    = rnd_coords();
      res_blk_index = fs ? 16'h0 : 16'(m_blk);
    end
    drain();
    n_vec += 3;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf: got %b want %b", overflow, m_ovf); end
    if (idx_err !== m_idx) begin n_err++; $display("FAIL rnd_idx: got %b want %b", idx_err, m_idx); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

`ifdef DISP_INVALID_COUNT_EN
  task automatic test_invalid_count();
    bit sel[8];
    int j;
    bit t;
    do_reset();
    conf_thresh = 8'h10;
    foreach (sel[i]) sel[i] = (i < 3);
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(0, i); t = sel[i]; sel[i] = sel[j]; sel[j] = t;
    end
    for (int i = 0; i < 8; i++)
      send(sel[i] ? (($urandom_range(0, 1) == 0) ? 16'hFFFF : {8'($urandom_range(0, 15)), 8'h40})
                  : {8'($urandom_range(16, 255)), 8'h48}, i, 0);
    idle(1);
    @(negedge clk);
    n_vec++;
    if (invalid_count !== 16'd3) begin n_err++; $display("FAIL inv_count3: got %0d want 3", invalid_count); end
    for (int i = 0; i < 8; i++) send({8'($urandom_range(16, 255)), 8'h50}, i, 0);
    idle(1);
    @(negedge clk);
    n_vec++;
    if (invalid_count !== 16'd0) begin n_err++; $display("FAIL inv_count0: got %0d want 0", invalid_count); end
    drain();
    obs_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pack_mask();
    test_framing();
    test_overflow();
    test_midword_fs();
    test_index();
    test_random();
`ifdef DISP_INVALID_COUNT_EN
    test_invalid_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
